ram_stream_reader: RTL
======================

Name: ram_stream_reader

Overview:
- Initiator for the single-port synchronous RAM.
- Accepts a burst command (start address, length) and issues sequential reads on the RAM port. The RAM has 1-cycle registered read latency.
- Streams the returned words out on a valid/ready interface and marks the final word.
- A 2-entry buffer absorbs the read latency, so the stream runs at full rate with out_ready high and loses nothing under backpressure.

Parameters:
data_width, 8, RAM word width / out_data width
address_width, 7, RAM address width; memory depth = 2**address_width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at an edge
cmd_addr  input  address_width  first word address
cmd_len  input  address_width+1  word count, 0..2**address_width
ram_we  output  1  RAM write enable, constant 0
ram_add  output  address_width  RAM address
ram_data_w  output  data_width  RAM write data, constant 0
ram_data_r  input  data_width  RAM read data, valid one cycle after the address is presented
out_valid  output  1  stream word available
out_ready  input  1  downstream accepts word
out_data  output  data_width  stream word
out_last  output  1  high with the final word of the burst
busy  output  1  high from command accept until done
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock domain, clk. rst_n asynchronous active-low.
- Reset values:
  - cmd_ready=1
  - ram_add=0
  - out_valid=0, out_data=0, out_last=0
  - busy=0, done=0
  - buffer empty, pending-read flag clear, counters 0
- Reset mid-burst: immediate abort, buffer flushed, in-flight read discarded, no done pulse.
- States: IDLE, READ, DRAIN.
  - IDLE: cmd_ready=1. On cmd handshake with cmd_len>0: latch cmd_addr into ram_add, load issue and deliver counters with cmd_len, busy=1, go to READ. Otherwise stay in IDLE.
  - cmd_len=0: accepted, no reads, no output. done pulses the next cycle. busy stays 0.
  - cmd_ready=0 outside IDLE. Commands are not queued.
  - READ:
    - A read is issued in a cycle when issue count>0 AND (buffer count + pending − pop) < 2, where pop = out_valid && out_ready.
    - Issuing sets pending for the next cycle, increments ram_add modulo 2**address_width (wraps 127→0 at default), and decrements the issue count.
    - When the issue count reaches 0, go to DRAIN.
  - DRAIN: no issues. Wait for the deliver count to reach 0, then pulse done and go to IDLE.
- Pending-read tracking: the RAM updates ram_data_r every edge. A separate pending flag tracks which cycles carry requested data.
  - When pending=1, ram_data_r is written into the 2-entry FIFO at that edge.
  - Credit rule guarantees no overflow, including a simultaneous push and pop.
- Output stream:
  - out_valid = FIFO non-empty. out_data = FIFO head.
  - out_last = 1 when the head is the final word (deliver count == 1).
  - out_data and out_last are held stable while out_valid && !out_ready.
- Latency: cmd handshake at edge E0 → ram_add valid after E0 → ram_data_r valid after E1 → FIFO write at E2 → out_valid high after E2.
- Throughput: with out_ready held high, one word per cycle, no bubbles after the first word.
- Completion: deliver count decrements on each pop. The pop of the last word (edge Ek) makes done=1 and busy=0 after Ek for one cycle. cmd_ready=1 after Ek.
- Full-memory burst: cmd_len = 2**address_width reads every location once, wrapping through 0.

Test Plan:
- Preload mem[i]=i+8'h10. Send addr=5, len=4, out_ready=1 → out_valid first high after the 2nd edge past accept; out_data 15,16,17,18 on consecutive cycles; out_last only on 18; done one pulse after 18; busy low after.
- Send addr=126, len=4 → ram_add sequence 126,127,0,1; out_data 8E,8F,10,11.
- Send addr=0, len=6 with out_ready toggled 1,0,0,1,0,1… → words 10..15 in order, no drops or duplicates; data held while stalled; at most 2 buffered, so no issue when credit=0.
- Send cmd_len=0 → no out_valid, done pulses once the cycle after accept, cmd_ready stays 1.
- Assert rst_n low during the 3rd word of a len=8 burst, then release and send addr=0, len=2 → all outputs reset immediately, no done; new burst returns 10,11 cleanly.
- Send len=128 from addr=64 → 128 words, addresses 64..127,0..63; ram_we stays 0 throughout.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM port and output stream signals of the burst reader
interface ram_stream_reader_if #(
  parameter int data_width = 8,
  parameter int address_width = 7
);
  logic cmd_valid;
  logic cmd_ready;
  logic [address_width-1:0] cmd_addr;
  logic [address_width:0] cmd_len;
  logic ram_we;
  logic [address_width-1:0] ram_add;
  logic [data_width-1:0] ram_data_w;
  logic [data_width-1:0] ram_data_r;
  logic out_valid;
  logic out_ready;
  logic [data_width-1:0] out_data;
  logic out_last;
  logic busy;
  logic done;
  modport master (
    input cmd_valid, cmd_addr, cmd_len, ram_data_r, out_ready,
    output cmd_ready, ram_we, ram_add, ram_data_w, out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_data_r, out_ready,
    input cmd_ready, ram_we, ram_add, ram_data_w, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader that streams sequential RAM words out through a 2-entry buffer
module ram_stream_reader #(
  parameter int data_width = 8,
  parameter int address_width = 7
) (
  input logic clk,
  input logic rst_n,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_next;
  logic [address_width:0] issue_cnt, deliver_cnt;
  logic [address_width-1:0] add;
  logic [data_width-1:0] fifo [2];
  logic [1:0] count;
  logic pending, done_q, wr_ptr, rd_ptr;
  logic cmd_ready, busy, issue, accept, pop, last_pop;
  assign accept = bus.cmd_valid && cmd_ready;
  assign pop = (count != 2'd0) && bus.out_ready;
  assign last_pop = pop && (deliver_cnt == 1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // next state: start on a non-empty command, drain once every read is issued, finish on the last pop
  always_comb begin
    state_next = state;
    if (state == IDLE && accept && bus.cmd_len != 0) state_next = READ;
    else if (state == READ && issue && issue_cnt == 1) state_next = DRAIN;
    else if (state == DRAIN && last_pop) state_next = IDLE;
  end
  // outputs: a read issues only while buffer plus in-flight read, after this cycle's pop, stays below 2
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    issue = state == READ && issue_cnt != 0 && ({1'b0, count} + 3'(pending)) < (3'd2 + 3'(pop));
  end
  // datapath: address/counters, in-flight read flag, buffer and completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      add <= '0;
      issue_cnt <= '0;
      deliver_cnt <= '0;
      pending <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      done_q <= 1'b0;
    end else begin
      if (accept && bus.cmd_len != 0) begin
        add <= bus.cmd_addr;
        issue_cnt <= bus.cmd_len;
        deliver_cnt <= bus.cmd_len;
      end else begin
        if (issue) begin
          add <= add + 1'b1;
          issue_cnt <= issue_cnt - 1'b1;
        end
        if (pop) deliver_cnt <= deliver_cnt - 1'b1;
      end
      pending <= issue;
      if (pending) begin
        fifo[wr_ptr] <= bus.ram_data_r;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(pending) - 2'(pop);
      done_q <= (accept && bus.cmd_len == 0) || last_pop;
    end
  assign bus.cmd_ready = cmd_ready;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.ram_we = 1'b0;
  assign bus.ram_data_w = '0;
  assign bus.ram_add = add;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_data = fifo[rd_ptr];
  assign bus.out_last = (count != 2'd0) && (deliver_cnt == 1);
endmodule
